// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the register write-back unit.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : DEPTH-entry in-order FIFO of write-back entries; exposes all
//               entries in age order (index 0 = head) with a valid vector.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  wb_entry_t              i_entry,
    output wb_entry_t              o_entries [DEPTH],
    output logic [DEPTH-1:0]       o_valid,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_push = i_push && (r_count < CW'(DEPTH));
    assign w_do_pop  = i_pop  && (r_count != '0);
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage carries no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            o_entries[k] = r_mem[r_rd_ptr + PW'(k)];
            o_valid[k]   = (CW'(k) < r_count);
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback_unit
// Description : Merges ALU and load results into an in-order queue that drives
//               the register-file write port; exports a pending-write mask.
//               Optional forwarding lookup enabled by macro WB_FORWARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback_unit
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   aluValid,
    output logic                   aluReady,
    input  logic [ADDR_W-1:0]      aluDest,
    input  logic [DATA_W-1:0]      aluData,
    input  logic                   memValid,
    output logic                   memReady,
    input  logic [ADDR_W-1:0]      memDest,
    input  logic [DATA_W-1:0]      memData,
    output logic [ADDR_W-1:0]      writeRegister,
    output logic [DATA_W-1:0]      writeData,
    output logic                   regWrite,
    output logic [31:0]            pendingMask,
`ifdef WB_FORWARD_EN
    input  logic [ADDR_W-1:0]      fwdAddr,
    output logic                   fwdHit,
    output logic [DATA_W-1:0]      fwdData,
`endif
    output logic [$clog2(DEPTH):0] fifoCount
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t         w_entries [DEPTH];
    logic [DEPTH-1:0]  w_valid;
    logic [CW-1:0]     w_count;
    logic              w_space;
    logic              w_mem_fire;
    logic              w_alu_fire;
    wb_entry_t         w_in;
    logic              w_push;
    logic              w_pop;

    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;
    logic              r_reg_write;

    // Readiness uses start-of-cycle occupancy; a same-cycle pop frees nothing.
    assign w_space  = (w_count < CW'(DEPTH));
    assign memReady = !reset && w_space;
    assign aluReady = !reset && w_space && !memValid;

    assign w_mem_fire = memValid && memReady;
    assign w_alu_fire = aluValid && aluReady;
    assign w_in.dest  = w_mem_fire ? memDest : aluDest;
    assign w_in.data  = w_mem_fire ? memData : aluData;
    // Writes to r0 complete the handshake but are discarded here.
    assign w_push     = (w_mem_fire || w_alu_fire) && (w_in.dest != REG_ZERO);
    assign w_pop      = (w_count != '0);

    wb_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_entry   (w_in),
        .o_entries (w_entries),
        .o_valid   (w_valid),
        .o_count   (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            r_reg_write <= w_pop;
            if (w_pop) begin
                r_write_reg  <= w_entries[0].dest;
                r_write_data <= w_entries[0].data;
            end
        end
    end

    assign writeRegister = r_write_reg;
    assign writeData     = r_write_data;
    assign regWrite      = r_reg_write;
    assign fifoCount     = w_count;

    always_comb begin
        pendingMask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_valid[k]) begin
                pendingMask[w_entries[k].dest] = 1'b1;
            end
        end
        if (r_reg_write) begin
            pendingMask[r_write_reg] = 1'b1;
        end
    end

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        if (r_reg_write && (r_write_reg == fwdAddr)) begin
            fwdHit  = 1'b1;
            fwdData = r_write_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (w_valid[k] && (w_entries[k].dest == fwdAddr)) begin
                fwdHit  = 1'b1;
                fwdData = w_entries[k].data;
            end
        end
        if (fwdAddr == REG_ZERO) begin
            fwdHit  = 1'b0;
            fwdData = '0;
        end
    end
`endif

endmodule
`default_nettype wire
